data_mem_ctrl: RTL
==================

// Module: data_mem_ctrl
// PURPOSE
//   Parametrised byte-addressed, big-endian data memory for the MEM stage.
//   Adds byte/half/word access, sign/zero extension, alignment and range checks,
//   a registered 1-cycle read port, and a post-reset clear sweep with ready handshake.
// PARAMETERS
//   DEPTH_BYTES  1024  memory size in bytes; power of 2, multiple of 4, >= 8
//   ADDR_W       32    width of Address port
// PORTS
//   clk       in   1       clock; all state updates on posedge
//   rst       in   1       synchronous, active-high reset
//   Address   in   ADDR_W  byte address of access
//   data      in   32      store data, right-justified for byte/half
//   MemRead   in   1       load request (sampled when ready=1)
//   MemWrite  in   1       store request (sampled when ready=1)
//   size      in   2       00 byte, 01 half, 10 word, 11 reserved -> error
//   uns       in   1       1 = zero-extend loads, 0 = sign-extend
//   ready     out  1       1 = requests accepted this cycle
//   DM_data   out  32      load result, registered
//   rd_valid  out  1       1-cycle pulse: DM_data valid (one per accepted load)
//   err       out  1       1-cycle pulse: previous accepted request faulted
// BEHAVIOUR
//   Reset: rst=1 at an edge -> state INIT, clr_ptr=0; ready=0, DM_data=0,
//     rd_valid=0, err=0. Applies identically mid-sweep or mid-operation;
//     in-flight load result is dropped (no rd_valid).
//   FSM INIT: each cycle zero 4 bytes at clr_ptr, clr_ptr+=4; after the edge
//     writing byte DEPTH_BYTES-4 -> IDLE. ready=0 throughout; requests ignored.
//     Clear takes DEPTH_BYTES/4 cycles after rst deasserts.
//   FSM IDLE: ready=1; never leaves except via rst.
//   Fault (checked when MemRead|MemWrite accepted): size=11, half with A[0]=1,
//     word with A[1:0]!=0, or A+bytes-1 >= DEPTH_BYTES (use full ADDR_W
//     compare, no wrap). Faulted access touches no memory; next cycle err=1,
//     and if MemRead was set rd_valid=1 with DM_data=0.
//   Endianness: byte A is most significant. Word: Mem[A..A+3]=data[31:0].
//     Half: Mem[A]=data[15:8], Mem[A+1]=data[7:0]. Byte: Mem[A]=data[7:0].
//   Load latency: request at edge N -> DM_data/rd_valid valid after edge N
//     (readable during cycle N+1). rd_valid low on cycles with no load;
//     DM_data holds last value when no load.
//   Extension: byte -> {24{uns?0:b[7]},b}; half -> {16{uns?0:h[15]},h}.
//   MemRead & MemWrite same cycle, same address: write applied first, load
//     returns the newly written bytes (write-then-read).
//   Store then load next cycle: load sees stored value (no stall, no bypass
//     needed since write commits at the earlier edge).
//   Back-to-back loads every cycle sustained; throughput 1 access/cycle.
//   err and rd_valid are independent pulses; a faulted store pulses err only.
// TESTING
//   rst 1 cycle, then count cycles with ready=0 -> exactly DEPTH_BYTES/4;
//     word load of every aligned address after -> 0.
//   Word store 0x12345678 @0x10; byte loads @0x10..0x13, uns=1 ->
//     0x12,0x34,0x56,0x78; half load @0x12 uns=1 -> 0x5678.
//   Byte store 0x80 @0x21; load byte uns=0 -> 0xFFFFFF80, uns=1 -> 0x00000080;
//     half store 0xBEEF @0x22, load half uns=0 -> 0xFFFFBEEF.
//   Word load @0x06, half store @0x03, word load @DEPTH_BYTES-2,
//     size=11 -> err=1 each, rd_valid=1 with DM_data=0 for loads,
//     target memory unchanged.
//   MemRead+MemWrite word 0xCAFEF00D @0x40 same cycle -> DM_data=0xCAFEF00D
//     next cycle; store @0x44 then load @0x44 next cycle -> stored value.
//   Assert rst mid-sweep and one cycle after a load request -> sweep restarts
//     from 0, no rd_valid for dropped load, all outputs 0 after the edge.

Source files
------------

// File: rtl/data_mem_ctrl.sv
// ---------------------------------------------------------------------------
// data_mem_ctrl
//   Byte-addressed, big-endian data memory for the MEM stage. Supports byte,
//   half and word loads/stores with sign/zero extension, alignment and range
//   fault detection, a registered one-cycle read port, and a post-reset clear
//   sweep that holds o_ready low until every byte has been zeroed.
//
// Ports
//   i_clk        clock, all state updates on posedge
//   i_rst        synchronous, active-high reset
//   i_address    byte address of the access
//   i_data       store data, right-justified for byte/half
//   i_mem_read   load request (sampled while o_ready=1)
//   i_mem_write  store request (sampled while o_ready=1)
//   i_size       00 byte, 01 half, 10 word, 11 reserved (faults)
//   i_uns        1 = zero-extend loads, 0 = sign-extend
//   o_ready      1 = requests are accepted this cycle
//   o_dm_data    registered load result
//   o_rd_valid   one-cycle pulse, o_dm_data valid
//   o_err        one-cycle pulse, previous accepted request faulted
// ---------------------------------------------------------------------------
module data_mem_ctrl #(
    parameter int DEPTH_BYTES = 1024,
    parameter int ADDR_W      = 32
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [ADDR_W-1:0] i_address,
    input  logic [31:0]       i_data,
    input  logic              i_mem_read,
    input  logic              i_mem_write,
    input  logic [1:0]        i_size,
    input  logic              i_uns,
    output logic              o_ready,
    output logic [31:0]       o_dm_data,
    output logic              o_rd_valid,
    output logic              o_err
);

    localparam int              IDX_W    = $clog2(DEPTH_BYTES);
    localparam logic [IDX_W-1:0] LAST_CLR = IDX_W'(DEPTH_BYTES - 4);

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic {ST_INIT, ST_IDLE} state_t;

    state_t            r_state;
    logic [IDX_W-1:0]  r_clr_ptr;
    logic              r_ready;
    logic [31:0]       r_dm_data;
    logic              r_rd_valid;
    logic              r_err;

    // NOTE: the storage array has no reset term; it is zeroed by the
    // clear sweep, which keeps it mappable onto plain RAM.
    logic [7:0]        r_mem [DEPTH_BYTES];

    logic [IDX_W-1:0]  w_idx0, w_idx1, w_idx2, w_idx3;
    logic [IDX_W-1:0]  w_clr1, w_clr2, w_clr3;
    logic [1:0]        w_nbytes_m1;
    logic [ADDR_W:0]   w_last_byte;
    logic              w_range_bad;
    logic              w_fault;
    logic              w_accept;
    logic              w_do_store;
    logic [31:0]       w_raw;
    logic [31:0]       w_load;

    assign w_idx0 = i_address[IDX_W-1:0];
    assign w_idx1 = w_idx0 + IDX_W'(1);
    assign w_idx2 = w_idx0 + IDX_W'(2);
    assign w_idx3 = w_idx0 + IDX_W'(3);

    assign w_clr1 = r_clr_ptr + IDX_W'(1);
    assign w_clr2 = r_clr_ptr + IDX_W'(2);
    assign w_clr3 = r_clr_ptr + IDX_W'(3);

    always_comb begin
        // NOTE: default first so every path assigns and no latch is inferred.
        w_nbytes_m1 = 2'd0;
        case (i_size)
            SZ_HALF: w_nbytes_m1 = 2'd1;
            SZ_WORD: w_nbytes_m1 = 2'd3;
            default: w_nbytes_m1 = 2'd0;
        endcase
    end

    // One extra bit so an access near the top of the address space cannot
    // wrap around and appear in range.
    assign w_last_byte = {1'b0, i_address} + {{(ADDR_W-1){1'b0}}, w_nbytes_m1};
    assign w_range_bad = (w_last_byte >= (ADDR_W+1)'(DEPTH_BYTES));

    assign w_fault = (i_size == 2'b11)
                  || ((i_size == SZ_HALF) && i_address[0])
                  || ((i_size == SZ_WORD) && (i_address[1:0] != 2'b00))
                  || w_range_bad;

    assign w_accept   = (r_state == ST_IDLE) && (i_mem_read || i_mem_write);
    assign w_do_store = w_accept && i_mem_write && !w_fault && !i_rst;

    // Load data before extension. A simultaneous store commits at the same
    // edge, so its data is forwarded to give write-then-read semantics.
    always_comb begin
        w_raw = '0;
        if (i_mem_write) begin
            case (i_size)
                SZ_BYTE: w_raw = {24'b0, i_data[7:0]};
                SZ_HALF: w_raw = {16'b0, i_data[15:0]};
                SZ_WORD: w_raw = i_data;
                default: w_raw = '0;
            endcase
        end else begin
            case (i_size)
                SZ_BYTE: w_raw = {24'b0, r_mem[w_idx0]};
                SZ_HALF: w_raw = {16'b0, r_mem[w_idx0], r_mem[w_idx1]};
                SZ_WORD: w_raw = {r_mem[w_idx0], r_mem[w_idx1],
                                  r_mem[w_idx2], r_mem[w_idx3]};
                default: w_raw = '0;
            endcase
        end
    end

    always_comb begin
        w_load = w_raw;
        if (!i_uns) begin
            case (i_size)
                SZ_BYTE: w_load[31:8]  = {24{w_raw[7]}};
                SZ_HALF: w_load[31:16] = {16{w_raw[15]}};
                default: w_load = w_raw;
            endcase
        end
    end

    // Storage: clear sweep during INIT, big-endian stores in IDLE.
    always_ff @(posedge i_clk) begin
        if (r_state == ST_INIT) begin
            r_mem[r_clr_ptr] <= 8'h00;
            r_mem[w_clr1]    <= 8'h00;
            r_mem[w_clr2]    <= 8'h00;
            r_mem[w_clr3]    <= 8'h00;
        end else if (w_do_store) begin
            case (i_size)
                SZ_BYTE: r_mem[w_idx0] <= i_data[7:0];
                SZ_HALF: begin
                    r_mem[w_idx0] <= i_data[15:8];
                    r_mem[w_idx1] <= i_data[7:0];
                end
                SZ_WORD: begin
                    r_mem[w_idx0] <= i_data[31:24];
                    r_mem[w_idx1] <= i_data[23:16];
                    r_mem[w_idx2] <= i_data[15:8];
                    r_mem[w_idx3] <= i_data[7:0];
                end
                default: ;
            endcase
        end
    end

    // Control FSM with registered outputs.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= ST_INIT;
            r_clr_ptr  <= '0;
            r_ready    <= 1'b0;
            r_dm_data  <= '0;
            r_rd_valid <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            case (r_state)
                ST_INIT: begin
                    r_rd_valid <= 1'b0;
                    r_err      <= 1'b0;
                    r_clr_ptr  <= r_clr_ptr + IDX_W'(4);
                    if (r_clr_ptr == LAST_CLR) begin
                        r_state <= ST_IDLE;
                        r_ready <= 1'b1;
                    end
                end
                ST_IDLE: begin
                    r_ready    <= 1'b1;
                    r_rd_valid <= w_accept && i_mem_read;
                    r_err      <= w_accept && w_fault;
                    if (w_accept && i_mem_read) begin
                        r_dm_data <= w_fault ? 32'h0 : w_load;
                    end
                end
                default: r_state <= ST_INIT;
            endcase
        end
    end

    assign o_ready    = r_ready;
    assign o_dm_data  = r_dm_data;
    assign o_rd_valid = r_rd_valid;
    assign o_err      = r_err;

endmodule
